chacha_qr_byte_tx: RTL and testbench

//   Output side of the ChaCha quarter-round pin interface. Accepts one 128-bit QR result
//   (words a,b,c,d) from the QR core and streams it to the host one byte at a time.

---
 rtl/chacha_pkg.sv | 18 +
 rtl/chacha_qr_byte_tx_if.sv | 31 +++
 rtl/ack_sync_edge.sv | 33 +++
 rtl/chacha_qr_byte_tx.sv | 107 ++++++++++
 tb/tb_chacha_qr_byte_tx.sv | 249 ++++++++++++++++++++++++
 5 files changed

// File: rtl/chacha_pkg.sv
// Shared definitions for the ChaCha quarter-round pin interface.
// Used by the byte-serial output streamer (chacha_qr_byte_tx) and by the
// byte-serial input loader, so both sides agree on widths and state names.
package chacha_pkg;

  localparam int WORD_W      = 32;                 // one ChaCha word
  localparam int NUM_WORDS   = 4;                  // a, b, c, d
  localparam int QR_W        = WORD_W * NUM_WORDS; // one QR result, 128 bits
  localparam int QR_BYTES    = QR_W / 8;           // 16 bytes per result
  localparam int BIDX_W      = 4;                  // byte index 0..15
  localparam int DEF_SETTLE  = 3;                  // ack synchronizer settle cycles

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_e;

endpackage

// File: rtl/chacha_qr_byte_tx_if.sv
// Bundle between the QR core / host pins and the byte streamer.
//   load_valid, load_data, load_ready : result hand-off from the QR core
//   ack_pin                           : raw asynchronous host acknowledge
//   tx_data, tx_valid, byte_idx       : byte currently presented to the host
//   busy, done                        : status
// The slave modport is the streamer's view; master is the driving side.
interface chacha_qr_byte_tx_if
  import chacha_pkg::*;
();

  logic              load_valid;
  logic [QR_W-1:0]   load_data;
  logic              load_ready;
  logic              ack_pin;
  logic [7:0]        tx_data;
  logic              tx_valid;
  logic [BIDX_W-1:0] byte_idx;
  logic              busy;
  logic              done;

  modport master (
    output load_valid, load_data, ack_pin,
    input  load_ready, tx_data, tx_valid, byte_idx, busy, done
  );

  modport slave (
    input  load_valid, load_data, ack_pin,
    output load_ready, tx_data, tx_valid, byte_idx, busy, done
  );

endinterface

// File: rtl/ack_sync_edge.sv
// Three-flop synchronizer with rising-edge detect for a raw asynchronous pin.
//   clk  : clock
//   rst  : synchronous reset, active-high; clears all three flops
//   pin  : asynchronous input
//   rise : one-cycle pulse, high the cycle after the second flop sees a 1
// A pin rising before edge E0 produces rise between E1 and E2.
module ack_sync_edge (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic rise
);

  logic s1, s2, s3;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbour; blocking here would collapse the chain.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= pin;
      s2 <= s1;
      s3 <= s2;
    end
  end

  // s3 is the delayed copy of s2, so a held-high pin yields a single pulse.
  assign rise = s2 & ~s3;

endmodule

// File: rtl/chacha_qr_byte_tx.sv
// Streams one 128-bit quarter-round result to the host one byte at a time.
//   clk, rst : clock; synchronous active-high reset
//   bus      : chacha_qr_byte_tx_if.slave
//     load_valid/load_data/load_ready : accept a result {d,c,b,a} in IDLE
//     ack_pin                         : host acknowledge, rising edge advances
//     tx_data/tx_valid/byte_idx       : byte k = load_data[8k+7:8k], a first
//     busy                            : state != IDLE
//     done                            : one-cycle pulse after the last byte's ack
// The pin wrapper drives uo_out = tx_data, uio_out[1] = tx_valid, uio_oe = 8'h02.
module chacha_qr_byte_tx
  import chacha_pkg::*;
#(
  parameter int SETTLE = DEF_SETTLE
) (
  input  logic                clk,
  input  logic                rst,
  chacha_qr_byte_tx_if.slave  bus
);

  localparam int SETTLE_W = $clog2(SETTLE + 1);

  tx_state_e         state, state_nxt;
  logic [QR_W-1:0]   shift_buf;
  logic [SETTLE_W-1:0] settle_cnt;
  logic [7:0]        tx_data_q;
  logic              tx_valid_q;
  logic [BIDX_W-1:0] byte_idx_q;
  logic              done_q;

  logic ack_edge;
  logic ready;
  logic accept;
  logic last_ack;
  logic advance;

  ack_sync_edge u_ack_sync (
    .clk  (clk),
    .rst  (rst),
    .pin  (bus.ack_pin),
    .rise (ack_edge)
  );

  // load_ready stays low after reset until the synchronizer has flushed any
  // level already present on the pin, so a stale high cannot skip byte 0.
  assign ready    = (state == IDLE) && (settle_cnt == '0);
  assign accept   = ready && bus.load_valid;
  assign last_ack = (state == SEND) && ack_edge &&
                    (byte_idx_q == BIDX_W'(QR_BYTES - 1));
  assign advance  = (state == SEND) && ack_edge && !last_ack;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  // NOTE: next-state starts from a default so every path assigns it and no
  // latch is inferred.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (accept)   state_nxt = SEND;
      SEND:    if (last_ack) state_nxt = IDLE;
      default:               state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      settle_cnt <= SETTLE_W'(SETTLE);
      tx_data_q  <= '0;
      tx_valid_q <= 1'b0;
      byte_idx_q <= '0;
      done_q     <= 1'b0;
    end else begin
      if (settle_cnt != '0) settle_cnt <= settle_cnt - SETTLE_W'(1);
      done_q <= last_ack;
      if (accept) begin
        tx_data_q  <= bus.load_data[7:0];
        tx_valid_q <= 1'b1;
        byte_idx_q <= '0;
      end else if (advance) begin
        // shift_buf[7:0] is the byte on the pins; the next one sits above it.
        tx_data_q  <= shift_buf[15:8];
        byte_idx_q <= byte_idx_q + BIDX_W'(1);
      end else if (last_ack) begin
        tx_data_q  <= '0;
        tx_valid_q <= 1'b0;
        byte_idx_q <= '0;
      end
    end
  end

  // NOTE: the 128-bit buffer is deliberately not reset: it is only observed
  // through tx_data, which is reset and reloaded on every accept.
  always_ff @(posedge clk) begin
    if (accept)       shift_buf <= bus.load_data;
    else if (advance) shift_buf <= shift_buf >> 8;
  end

  assign bus.load_ready = ready;
  assign bus.tx_data    = tx_data_q;
  assign bus.tx_valid   = tx_valid_q;
  assign bus.byte_idx   = byte_idx_q;
  assign bus.busy       = (state != IDLE);
  assign bus.done       = done_q;

endmodule

// File: tb/tb_chacha_qr_byte_tx.sv
// Self-checking bench for chacha_qr_byte_tx. The reference model treats a
// result as a plain 128-bit number whose k-th byte is the k-th one sent, and
// times the host acknowledge as "visible three edges after the pin rises".
module tb_chacha_qr_byte_tx;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   passed = 0;

  chacha_qr_byte_tx_if bus ();

  chacha_qr_byte_tx dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  initial begin
    #2ms;
    $display("FAIL watchdog: simulation time limit reached, got timeout, want completion");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [127:0] rand_result();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // Wait (bounded) for load_ready, then offer data for one cycle.
  task automatic load(input logic [127:0] data);
    int n = 0;
    while (bus.load_ready !== 1'b1 && n < 20) begin
      tick;
      n++;
    end
    checks++;
    if (bus.load_ready !== 1'b1)
      $display("FAIL load_ready_wait: load_ready=%b after %0d cycles, want 1", bus.load_ready, n);
    else passed++;
    bus.load_valid = 1'b1;
    bus.load_data  = data;
    tick;
    bus.load_valid = 1'b0;
    bus.load_data  = rand_result();
  endtask

  // Present-and-acknowledge bytes from_k..to_k of data. Reaching k=15 also
  // checks the return to IDLE and the done pulse.
  task automatic drain(input logic [127:0] data, input int from_k, input int to_k);
    for (int k = from_k; k <= to_k; k++) begin
      checks++;
      if (bus.tx_data !== data[8*k +: 8] || bus.byte_idx !== 4'(k) ||
          bus.tx_valid !== 1'b1 || bus.busy !== 1'b1 || bus.done !== 1'b0)
        $display("FAIL byte_%0d: data=%h idx=%0d valid=%b busy=%b done=%b, want data=%h idx=%0d valid=1 busy=1 done=0",
                 k, bus.tx_data, bus.byte_idx, bus.tx_valid, bus.busy, bus.done, data[8*k +: 8], k);
      else passed++;
      bus.ack_pin = 1'b1;
      tick;
      tick;
      checks++;
      if (bus.byte_idx !== 4'(k) || bus.tx_data !== data[8*k +: 8])
        $display("FAIL ack_latency_%0d: idx=%0d data=%h two edges after ack, want idx=%0d data=%h",
                 k, bus.byte_idx, bus.tx_data, k, data[8*k +: 8]);
      else passed++;
      tick;
      if (k == 15) begin
        checks++;
        if (bus.done !== 1'b1 || bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 ||
            bus.byte_idx !== 4'd0 || bus.load_ready !== 1'b1 || bus.busy !== 1'b0)
          $display("FAIL stream_end: done=%b valid=%b data=%h idx=%0d ready=%b busy=%b, want 1 0 00 0 1 0",
                   bus.done, bus.tx_valid, bus.tx_data, bus.byte_idx, bus.load_ready, bus.busy);
        else passed++;
      end
      bus.ack_pin = 1'b0;
      tick;
      if (k == 15) begin
        checks++;
        if (bus.done !== 1'b0 || bus.load_ready !== 1'b1)
          $display("FAIL done_pulse: done=%b ready=%b one cycle later, want done=0 ready=1",
                   bus.done, bus.load_ready);
        else passed++;
      end
      tick;
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    tick;
    checks++;
    if (bus.tx_data !== 8'h00 || bus.tx_valid !== 1'b0 || bus.byte_idx !== 4'd0 ||
        bus.busy !== 1'b0 || bus.done !== 1'b0 || bus.load_ready !== 1'b0)
      $display("FAIL reset_state: data=%h valid=%b idx=%0d busy=%b done=%b ready=%b, want all 0",
               bus.tx_data, bus.tx_valid, bus.byte_idx, bus.busy, bus.done, bus.load_ready);
    else passed++;
    rst = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      tick;
      checks++;
      if (bus.load_ready !== (i == 3))
        $display("FAIL reset_settle_%0d: load_ready=%b, want %b", i, bus.load_ready, (i == 3));
      else passed++;
    end
  endtask

  task automatic test_known_vector;
    logic [127:0] data = {32'h6b206574, 32'h79622d32, 32'h3320646e, 32'h61707865};
    logic [127:0] bytes_le = 128'h6b20_6574_7962_2d32_3320_646e_6170_7865;
    // Independent spelling of the expected wire order, first byte sent last.
    logic [127:0] wire_order = {8'h6b, 8'h20, 8'h65, 8'h74, 8'h79, 8'h62, 8'h2d, 8'h32,
                                8'h33, 8'h20, 8'h64, 8'h6e, 8'h61, 8'h70, 8'h78, 8'h65};
    checks++;
    if (bytes_le !== wire_order || data !== wire_order)
      $display("FAIL vector_setup: data=%h, want %h", data, wire_order);
    else passed++;
    load(data);
    drain(wire_order, 0, 15);
  endtask

  task automatic test_ack_held_high;
    logic [127:0] data = rand_result();
    load(data);
    drain(data, 0, 2);
    bus.ack_pin = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      tick;
      checks++;
      if (bus.byte_idx !== ((i >= 3) ? 4'd4 : 4'd3))
        $display("FAIL held_ack_cycle_%0d: idx=%0d, want %0d", i, bus.byte_idx, (i >= 3) ? 4 : 3);
      else passed++;
    end
    bus.ack_pin = 1'b0;
    tick;
    tick;
    drain(data, 4, 15);
  endtask

  task automatic test_idle_ack_ignored;
    for (int r = 0; r < 3; r++) begin
      for (int i = 0; i < 6; i++) begin
        bus.ack_pin = (i < 3);
        tick;
        checks++;
        if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.byte_idx !== 4'd0 || bus.busy !== 1'b0)
          $display("FAIL idle_ack_%0d_%0d: valid=%b data=%h idx=%0d busy=%b, want 0 00 0 0",
                   r, i, bus.tx_valid, bus.tx_data, bus.byte_idx, bus.busy);
        else passed++;
      end
    end
    bus.ack_pin = 1'b0;
    tick;
    tick;
  endtask

  task automatic test_reset_mid_stream;
    logic [127:0] data = rand_result();
    load(data);
    drain(data, 0, 6);
    rst = 1'b1;
    tick;
    rst = 1'b0;
    checks++;
    if (bus.tx_valid !== 1'b0 || bus.tx_data !== 8'h00 || bus.byte_idx !== 4'd0 ||
        bus.busy !== 1'b0 || bus.load_ready !== 1'b0)
      $display("FAIL midreset_state: valid=%b data=%h idx=%0d busy=%b ready=%b, want all 0",
               bus.tx_valid, bus.tx_data, bus.byte_idx, bus.busy, bus.load_ready);
    else passed++;
    for (int i = 1; i <= 3; i++) begin
      tick;
      checks++;
      if (bus.load_ready !== (i == 3) || bus.tx_valid !== 1'b0)
        $display("FAIL midreset_settle_%0d: ready=%b valid=%b, want ready=%b valid=0",
                 i, bus.load_ready, bus.tx_valid, (i == 3));
      else passed++;
    end
  endtask

  task automatic test_ack_high_through_reset;
    logic [127:0] data = rand_result();
    bus.ack_pin = 1'b1;
    rst = 1'b1;
    tick;
    rst = 1'b0;
    load(data);
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (bus.byte_idx !== 4'd0 || bus.tx_data !== data[7:0] || bus.tx_valid !== 1'b1)
        $display("FAIL stale_ack_%0d: idx=%0d data=%h valid=%b, want idx=0 data=%h valid=1",
                 i, bus.byte_idx, bus.tx_data, bus.tx_valid, data[7:0]);
      else passed++;
    end
    bus.ack_pin = 1'b0;
    tick;
    tick;
    drain(data, 0, 15);
  endtask

  task automatic test_load_during_send;
    logic [127:0] data = rand_result();
    logic [127:0] other = ~data;
    load(data);
    drain(data, 0, 4);
    bus.load_valid = 1'b1;
    bus.load_data  = other;
    for (int i = 0; i < 4; i++) begin
      tick;
      checks++;
      if (bus.tx_data !== data[47:40] || bus.byte_idx !== 4'd5 || bus.load_ready !== 1'b0)
        $display("FAIL load_in_send_%0d: data=%h idx=%0d ready=%b, want data=%h idx=5 ready=0",
                 i, bus.tx_data, bus.byte_idx, bus.load_ready, data[47:40]);
      else passed++;
    end
    bus.load_valid = 1'b0;
    drain(data, 5, 15);
  endtask

  task automatic test_back_to_back;
    for (int n = 0; n < 4; n++) begin
      logic [127:0] data = rand_result();
      load(data);
      drain(data, 0, 15);
    end
  endtask

  initial begin
    bus.load_valid = 1'b0;
    bus.load_data  = '0;
    bus.ack_pin    = 1'b0;
    test_reset;
    test_known_vector;
    test_ack_held_high;
    test_idle_ack_ignored;
    test_reset_mid_stream;
    test_ack_high_through_reset;
    test_load_during_send;
    test_back_to_back;
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
